// File: rtl/mux_sel_pkg.sv
// Shared state encoding and elaboration helpers for the registered N:1 select block.
package mux_sel_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  // Smallest r with 2**r >= v; used to validate the select width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// Combinational NUM_IN:1 word select; out-of-range codes yield zero with sel_err set.
module mux_nto1_comb #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_flat,
  output logic [WIDTH-1:0]        word,
  output logic                    sel_err
);

  // Unused codes fall through to the defaults, matching the legacy gate-level zero output.
  always_comb begin
    word    = '0;
    sel_err = 1'b1;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        word    = data_flat[i*WIDTH +: WIDTH];
        sel_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// N-to-1 select with a registered valid/ready output stage and one-entry skid buffer.
module mux_sel_pipe
  import mux_sel_pkg::*;
#(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_flat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err
);

  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $error("mux_sel_pipe: NUM_IN=%0d outside 2..16", NUM_IN);
  end
  if (clog2(NUM_IN) > SEL_W) begin : g_bad_sel_w
    $error("mux_sel_pipe: SEL_W=%0d too narrow for NUM_IN=%0d", SEL_W, NUM_IN);
  end

  state_t           state, state_nx;
  logic [WIDTH-1:0] mux_word, skid_data;
  logic             mux_err, skid_err;
  logic             in_fire, out_fire;
  logic             load_out, load_skid, skid_to_out;

  mux_nto1_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .sel       (sel),
    .data_flat (data_flat),
    .word      (mux_word),
    .sel_err   (mux_err)
  );

  // Handshake outputs decode only the registered state, so out_ready never reaches in_ready.
  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_SKID);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nx    = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (flush) begin
      state_nx = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_nx = ST_FULL;
            load_out = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            load_out = 1'b1;
          end else if (in_fire) begin
            state_nx  = ST_SKID;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nx = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_nx    = ST_FULL;
            skid_to_out = 1'b1;
          end
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_EMPTY;
      out_data    <= '0;
      out_sel_err <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_out) begin
        out_data    <= mux_word;
        out_sel_err <= mux_err;
      end else if (skid_to_out) begin
        out_data    <= skid_data;
        out_sel_err <= skid_err;
      end
      if (load_skid) begin
        skid_data <= mux_word;
        skid_err  <= mux_err;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: default 5-bit/3-input instance plus a 32-bit/8-input streaming instance.
module tb_mux_sel_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } ent_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, flush;
  logic         in_valid5, in_ready5, out_valid5, out_ready5, err5;
  logic [1:0]   sel5;
  logic [14:0]  data5;
  logic [4:0]   out_data5;
  logic         in_valid32, in_ready32, out_valid32, out_ready32, err32;
  logic [2:0]   sel32;
  logic [255:0] data32;
  logic [31:0]  out_data32;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned n32_out = 0;
  ent_t q5[$];
  ent_t q32[$];

  mux_sel_pipe dut5 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid5), .in_ready(in_ready5), .sel(sel5), .data_flat(data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5), .out_sel_err(err5)
  );

  mux_sel_pipe #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) dut32 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid32), .in_ready(in_ready32), .sel(sel32), .data_flat(data32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32), .out_sel_err(err32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic ent_t ref5(input logic [1:0] s, input logic [14:0] d);
    ent_t r;
    r.e = (s >= 2'd3);
    r.d = r.e ? 32'd0 : ((32'(d) >> (32'(s) * 5)) & 32'h1f);
    return r;
  endfunction

  function automatic ent_t ref32(input logic [2:0] s, input logic [255:0] d);
    ent_t r;
    r.e = (int'(s) >= 8);
    r.d = r.e ? 32'd0 : 32'(d >> (int'(s) * 32));
    return r;
  endfunction

  // Two-entry FIFO model: ready while fewer than two words held, head is the visible output.
  task automatic cycle();
    bit   f5i, f5o, f32i, f32o;
    ent_t n5, n32;
    chk("valid5", out_valid5, q5.size() != 0);
    chk("ready5", in_ready5, q5.size() < 2);
    if (q5.size() != 0) begin
      chk("data5", out_data5, q5[0].d);
      chk("err5", err5, q5[0].e);
    end
    chk("valid32", out_valid32, q32.size() != 0);
    chk("ready32", in_ready32, q32.size() < 2);
    if (q32.size() != 0) begin
      chk("data32", out_data32, q32[0].d);
      chk("err32", err32, q32[0].e);
    end
    f5i  = in_valid5 && (q5.size() < 2);
    f5o  = out_ready5 && (q5.size() != 0);
    f32i = in_valid32 && (q32.size() < 2);
    f32o = out_ready32 && (q32.size() != 0);
    n5   = ref5(sel5, data5);
    n32  = ref32(sel32, data32);
    @(posedge clock);
    if (reset || flush) begin
      q5.delete();
      q32.delete();
    end else begin
      if (f5o) void'(q5.pop_front());
      if (f5i) q5.push_back(n5);
      if (f32o) begin
        void'(q32.pop_front());
        n32_out++;
      end
      if (f32i) q32.push_back(n32);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    in_valid5 = 1'b0; sel5 = '0; data5 = '0; out_ready5 = 1'b0;
    in_valid32 = 1'b0; sel32 = '0; data32 = '0; out_ready32 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_valid", out_valid5, 1'b0);
    chk("rst_ready", in_ready5, 1'b1);
    chk("rst_data", out_data5, 32'd0);
    chk("rst_err", err5, 1'b0);

    // Basic select and invalid select
    data5 = {5'd9, 5'd22, 5'd3};
    out_ready5 = 1'b1; in_valid5 = 1'b1; sel5 = 2'd1;
    cycle();
    chk("sel1_data", out_data5, 32'd22);
    sel5 = 2'd2;
    cycle();
    chk("sel2_data", out_data5, 32'd9);
    sel5 = 2'd3;
    cycle();
    chk("sel3_data", out_data5, 32'd0);
    chk("sel3_err", err5, 1'b1);
    in_valid5 = 1'b0;
    cycle();
    chk("single_beat", out_valid5, 1'b0);

    // Backpressure into skid, then drain in order
    out_ready5 = 1'b0; in_valid5 = 1'b1; sel5 = 2'd0;
    data5 = 15'd5; cycle();
    data5 = 15'd7; cycle();
    chk("skid_ready", in_ready5, 1'b0);
    data5 = 15'd11; cycle(); cycle();
    chk("skid_hold", out_data5, 32'd5);
    out_ready5 = 1'b1;
    cycle();
    chk("drain_b", out_data5, 32'd7);
    cycle();
    chk("drain_c", out_data5, 32'd11);
    in_valid5 = 1'b0;
    cycle(); cycle();

    // Flush while in SKID with a concurrent input
    out_ready5 = 1'b0; in_valid5 = 1'b1;
    data5 = 15'd13; cycle();
    data5 = 15'd14; cycle();
    data5 = 15'd15; flush = 1'b1; cycle();
    flush = 1'b0; in_valid5 = 1'b0; out_ready5 = 1'b1;
    chk("flush_valid", out_valid5, 1'b0);
    chk("flush_ready", in_ready5, 1'b1);
    cycle(); cycle();

    // Reset from FULL with in_valid high
    out_ready5 = 1'b0; in_valid5 = 1'b1; data5 = 15'd20;
    cycle();
    data5 = 15'd21; reset = 1'b1; cycle();
    reset = 1'b0; in_valid5 = 1'b0;
    chk("mrst_valid", out_valid5, 1'b0);
    chk("mrst_ready", in_ready5, 1'b1);
    chk("mrst_data", out_data5, 32'd0);
    cycle();
    in_valid5 = 1'b1; data5 = 15'd18; out_ready5 = 1'b1;
    cycle();
    chk("post_rst_data", out_data5, 32'd18);
    in_valid5 = 1'b0;
    cycle();

    // Random traffic on the small instance
    for (int i = 0; i < 80; i++) begin
      in_valid5  = 1'($urandom);
      out_ready5 = 1'($urandom);
      sel5       = 2'($urandom);
      data5      = 15'($urandom);
      flush      = ($urandom_range(0, 15) == 0);
      cycle();
    end
    flush = 1'b0; in_valid5 = 1'b0; out_ready5 = 1'b1;
    cycle(); cycle();

    // Streaming on the wide instance
    out_ready32 = 1'b1; in_valid32 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sel32 = 3'($urandom);
      for (int j = 0; j < 8; j++) data32[j*32 +: 32] = $urandom;
      cycle();
    end
    in_valid32 = 1'b0;
    cycle(); cycle();
    chk("stream_count", n32_out, 32'd100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised N-to-1 select block with a valid/ready registered output. Generalises the processor's fixed 3-input, 5-bit select.
- Captures the selected word into an output register, with a one-entry skid buffer so upstream stays fully decoupled from downstream stalls.
- Used on the destination-register-select and writeback-select paths between pipeline stages, where downstream can stall.

Parameters:
- WIDTH, 5, data width of each input and of the output.
- NUM_IN, 3, number of selectable inputs (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous pipeline flush; discards held entries.
- in_valid  in  1  upstream presents sel/data.
- in_ready  out  1  block can accept this cycle.
- sel  in  SEL_W  input index.
- data_flat  in  NUM_IN*WIDTH  input i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  out_data/out_sel_err valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  selected word.
- out_sel_err  out  1  the entry was captured with sel >= NUM_IN.

Behaviour:
- Reset is synchronous, active-high, sampled on the clock edge. It is stated so here and holds for every register.
- Reset values: out_valid=0, in_ready=1, out_data=0, out_sel_err=0, skid register=0, state=EMPTY.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Data and sel are sampled only on in_fire.
- Select rule:
  - sel < NUM_IN: the word is data_flat[sel*WIDTH +: WIDTH].
  - sel >= NUM_IN: the word is all-zero and err=1. This matches the legacy gate-level behaviour for the unused code.
- Latency: one cycle. A word accepted at edge k appears on out_data after edge k, with out_valid=1.
- States (two-bit, registered):
  - EMPTY: out_valid=0, in_ready=1.
    - in_fire -> FULL; the output register loads the word.
  - FULL: out_valid=1, in_ready=1.
    - in_fire & out_fire -> FULL; the output register loads the new word.
    - in_fire & !out_fire -> SKID; the skid register loads the new word and the output holds.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise stay in FULL.
  - SKID: out_valid=1, in_ready=0.
    - out_fire -> FULL; output register <= skid register.
    - Otherwise hold.
- in_ready is a register output, driven from the state. There is no combinational path from out_ready to in_ready.
- out_data and out_sel_err are direct register outputs. They are stable while out_valid=1 and out_ready=0.
- Ordering: strictly FIFO. The skid entry is never overtaken.
- flush = 1:
  - Next state EMPTY; out_valid=0, in_ready=1.
  - Any in_fire that cycle is discarded. Flush has priority over accept and over out_fire.
  - Data registers may hold stale values; the bench must not check them while out_valid=0.
- reset has priority over flush.
- Reset mid-transfer (FULL or SKID): both entries are dropped. Nothing is emitted after the reset edge until a new in_fire occurs.
- Throughput: one word per cycle while out_ready=1.
- No width conversion. WIDTH is preserved end-to-end, and sel is compared unsigned.

Decomposition:
- Package mux_sel_pkg holds:
  - state encoding constants: ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2;
  - a function clog2 used to check SEL_W.
- One sub-module: mux_nto1_comb. It is a purely combinational parametrised NUM_IN:1 mux over WIDTH bits and outputs the sel_err flag. It is instantiated once, in front of both registers.
- Elaboration check: NUM_IN > 2**SEL_W causes a generate-time error.

Test Plan:
- Basic select: defaults; data_flat={5'd9,5'd22,5'd3}, sel=1, out_ready=1 -> next cycle out_data=22, out_valid=1, out_sel_err=0. Then sel=2 -> out_data=9.
- Invalid select: sel=3 with the same data -> out_data=0, out_sel_err=1, single beat.
- Backpressure/skid:
  - out_ready=0; send A=5 (sel=0 on data 5) then B=7. The state reaches SKID and in_ready=0 on the following cycle.
  - C is held off; out_data stays 5.
  - Raise out_ready -> outputs in order 5, 7, then C. No loss or duplication.
- Streaming: WIDTH=32, NUM_IN=8, SEL_W=3. 100 random words with out_ready=1 -> one output per cycle, matching a scoreboard; in_ready constantly 1.
- Flush in SKID: fill to SKID, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1. Neither entry nor the flushed-cycle input is ever emitted.
- Reset mid-operation: in FULL, assert reset for 1 cycle while in_valid=1 -> out_valid=0, in_ready=1, out_data=0. The first post-reset word appears 1 cycle after its in_fire.
